// File: rtl/axi_ddr_pkg.sv
// rtl/axi_ddr_pkg.sv - shared constants, FSM encoding and helpers for the DDR write scheduler
//
// Purpose : common definitions for axi_wr_sched and wr_addr_gen.
// Contents: ADDR_W (byte address width), AXI_WIDTH_DEF / BYTES_PER_BEAT,
//           wr_state_t (arbiter FSM states), burst_bytes() (bytes in one burst).

package axi_ddr_pkg;

  localparam int ADDR_W         = 29;
  localparam int AXI_WIDTH_DEF  = 256;
  localparam int BYTES_PER_BEAT = AXI_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } wr_state_t;

  // Bytes covered by one burst of AWLEN 'len' (beats = len + 1), one bit wider
  // than the address so the pointer advance can never wrap silently.
  function automatic logic [ADDR_W:0] burst_bytes(input logic [7:0] len, input int bpb);
    logic [ADDR_W:0] beats;
    beats       = (ADDR_W + 1)'({1'b0, len} + 9'd1);
    burst_bytes = beats * (ADDR_W + 1)'(bpb);
  endfunction

endpackage

// File: rtl/wr_addr_gen.sv
// rtl/wr_addr_gen.sv - per-channel frame pointer, ping-pong bank and deferred frame load
//
// Purpose : tracks where the next burst of one camera channel goes.
// Ports   : clk, rst         - clock, asynchronous active-high reset
//           beg_addr/end_addr - frame window (end exclusive)
//           burst_len         - AWLEN of each burst
//           pingpang          - toggle bank on every frame wrap
//           load              - frame-sync pulse
//           granted           - this channel currently owns the write master
//           advance           - burst of this channel completed this cycle
//           ptr, bank         - current frame pointer and bank

module wr_addr_gen
  import axi_ddr_pkg::*;
#(
  parameter int BYTES = BYTES_PER_BEAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] beg_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [7:0]        burst_len,
  input  logic              pingpang,
  input  logic              load,
  input  logic              granted,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              bank
);

  logic            pend_load;
  logic [ADDR_W:0] next_ptr;

  assign next_ptr = {1'b0, ptr} + burst_bytes(burst_len, BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      bank      <= 1'b0;
      pend_load <= 1'b0;
    end else if (advance) begin
      pend_load <= 1'b0;
      // A frame sync seen during (or at the end of) the burst restarts the
      // frame and takes priority over the normal increment/wrap.
      if (load || pend_load) begin
        ptr  <= beg_addr;
        bank <= 1'b0;
      end else if (next_ptr >= {1'b0, end_addr}) begin
        ptr <= beg_addr;
        if (pingpang) begin
          bank <= ~bank;
        end
      end else begin
        ptr <= next_ptr[ADDR_W-1:0];
      end
    end else if (load) begin
      // The in-flight burst address must not move, so defer the load.
      if (granted) begin
        pend_load <= 1'b1;
      end else begin
        ptr  <= beg_addr;
        bank <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_wr_sched.sv
// rtl/axi_wr_sched.sv - round-robin two-channel write burst scheduler for the DDR AXI master
//
// Purpose : shares one AXI write master between write FIFO 1 and 2, generating
//           burst address/length and steering FIFO read enables.
// Ports   : clk, rst                     - ui_clk, asynchronous active-high reset
//           wr_enable, pingpang          - global enable, ping-pong bank mode
//           wr_beg_addr_1/2, wr_end_addr_1/2 - frame windows
//           wr_burst_len                 - AWLEN (beats - 1)
//           wr_load_1/2                  - frame-sync pulses
//           fifo_cnt_1/2                 - FIFO read-side fill counts
//           axi_wr_ready, axi_writing, axi_wr_done - master status
//           axi_wr_start, axi_wr_addr, axi_wr_len  - burst request
//           wr_grant                     - one-hot owner
//           fifo_rd_en_1/2               - FIFO read enables
//           wr_bank_1/2                  - bank currently written
//           busy                         - grant until burst done

module axi_wr_sched
  import axi_ddr_pkg::*;
#(
  parameter int                AXI_WIDTH   = AXI_WIDTH_DEF,
  parameter int                CNT_W       = 10,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = 29'h100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enable,
  input  logic              pingpang,
  input  logic [ADDR_W-1:0] wr_beg_addr_1,
  input  logic [ADDR_W-1:0] wr_end_addr_1,
  input  logic [ADDR_W-1:0] wr_beg_addr_2,
  input  logic [ADDR_W-1:0] wr_end_addr_2,
  input  logic [7:0]        wr_burst_len,
  input  logic              wr_load_1,
  input  logic              wr_load_2,
  input  logic [CNT_W-1:0]  fifo_cnt_1,
  input  logic [CNT_W-1:0]  fifo_cnt_2,
  input  logic              axi_wr_ready,
  input  logic              axi_writing,
  input  logic              axi_wr_done,
  output logic              axi_wr_start,
  output logic [ADDR_W-1:0] axi_wr_addr,
  output logic [7:0]        axi_wr_len,
  output logic [1:0]        wr_grant,
  output logic              fifo_rd_en_1,
  output logic              fifo_rd_en_2,
  output logic              wr_bank_1,
  output logic              wr_bank_2,
  output logic              busy
);

  wr_state_t         state;
  logic              rr_last;   // 1 = channel 2 was served last
  logic [8:0]        need;
  logic              req_1;
  logic              req_2;
  logic              sel_2;
  logic [ADDR_W-1:0] ptr_1;
  logic [ADDR_W-1:0] ptr_2;
  logic [ADDR_W-1:0] addr_1;
  logic [ADDR_W-1:0] addr_2;
  logic              advance_1;
  logic              advance_2;

  // Beat count is formed at 9 bits so AWLEN = 255 asks for 256 words.
  assign need  = {1'b0, wr_burst_len} + 9'd1;
  assign req_1 = wr_enable & ({9'd0, fifo_cnt_1} >= {{CNT_W{1'b0}}, need});
  assign req_2 = wr_enable & ({9'd0, fifo_cnt_2} >= {{CNT_W{1'b0}}, need});

  // Channel 2 wins when it is the only requester, or both request and
  // channel 1 was served last.
  assign sel_2 = req_2 & (~req_1 | ~rr_last);

  assign addr_1 = ptr_1 + (wr_bank_1 ? BANK_OFFSET : '0);
  assign addr_2 = ptr_2 + (wr_bank_2 ? BANK_OFFSET : '0);

  assign advance_1 = (state == ST_WAIT) & axi_wr_done & wr_grant[0];
  assign advance_2 = (state == ST_WAIT) & axi_wr_done & wr_grant[1];

  assign fifo_rd_en_1 = axi_writing & wr_grant[0];
  assign fifo_rd_en_2 = axi_writing & wr_grant[1];

  wr_addr_gen #(.BYTES(AXI_WIDTH / 8)) u_gen_1 (
    .clk       (clk),
    .rst       (rst),
    .beg_addr  (wr_beg_addr_1),
    .end_addr  (wr_end_addr_1),
    .burst_len (wr_burst_len),
    .pingpang  (pingpang),
    .load      (wr_load_1),
    .granted   (wr_grant[0]),
    .advance   (advance_1),
    .ptr       (ptr_1),
    .bank      (wr_bank_1)
  );

  wr_addr_gen #(.BYTES(AXI_WIDTH / 8)) u_gen_2 (
    .clk       (clk),
    .rst       (rst),
    .beg_addr  (wr_beg_addr_2),
    .end_addr  (wr_end_addr_2),
    .burst_len (wr_burst_len),
    .pingpang  (pingpang),
    .load      (wr_load_2),
    .granted   (wr_grant[1]),
    .advance   (advance_2),
    .ptr       (ptr_2),
    .bank      (wr_bank_2)
  );

  // Address, length and grant are registered one cycle before the start
  // pulse becomes visible, so they are stable when the master samples them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_last      <= 1'b1;
      wr_grant     <= 2'b00;
      axi_wr_start <= 1'b0;
      axi_wr_addr  <= '0;
      axi_wr_len   <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          axi_wr_start <= 1'b0;
          if ((req_1 | req_2) & axi_wr_ready) begin
            wr_grant    <= sel_2 ? 2'b10 : 2'b01;
            axi_wr_addr <= sel_2 ? addr_2 : addr_1;
            axi_wr_len  <= wr_burst_len;
            busy        <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          axi_wr_start <= 1'b1;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          axi_wr_start <= 1'b0;
          if (axi_wr_done) begin
            rr_last  <= wr_grant[1];
            wr_grant <= 2'b00;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          axi_wr_start <= 1'b0;
          wr_grant     <= 2'b00;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
